// File: rtl/align_add.sv
// align_add: single-precision adder front end. Unpacks two operands, orders
// them by magnitude, aligns the smaller mantissa one bit per cycle, then adds
// or subtracts and holds the result until the normalizer takes it.
module align_add (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SUB,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [23:0] MANT,
    output logic        OVF,
    output logic [7:0]  EXP,
    output logic        SIGN
);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ADD,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Unpacked operand fields
    logic        a_hid, b_hid;
    logic [7:0]  a_eff, b_eff;
    logic [23:0] a_m, b_m;
    logic        b_sgn;
    logic        a_big;

    // Ordered operands and shift amount
    logic [23:0] l_m, s_m;
    logic        l_s, s_s;
    logic [7:0]  l_e, s_e;
    logic [7:0]  d;
    logic [4:0]  n;

    // Working registers
    logic [23:0] ml, ms;
    logic        sl, ss;
    logic [7:0]  el;
    logic [4:0]  cnt;

    // Unpack both operands and order them by magnitude (tie keeps A as larger)
    always_comb begin
        a_hid = |A[30:23];
        b_hid = |B[30:23];
        a_eff = a_hid ? A[30:23] : 8'd1;
        b_eff = b_hid ? B[30:23] : 8'd1;
        a_m   = {a_hid, A[22:0]};
        b_m   = {b_hid, B[22:0]};
        b_sgn = B[31] ^ SUB;
        a_big = (A[30:0] >= B[30:0]);

        if (a_big) begin
            l_m = a_m;   s_m = b_m;
            l_s = A[31]; s_s = b_sgn;
            l_e = a_eff; s_e = b_eff;
        end else begin
            l_m = b_m;   s_m = a_m;
            l_s = b_sgn; s_s = A[31];
            l_e = b_eff; s_e = a_eff;
        end

        d = l_e - s_e;
        n = (d >= 8'd24) ? 5'd24 : d[4:0];
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (IN_VALID) state_nxt = (n != 5'd0) ? ALIGN : ADD;
            ALIGN: if (cnt == 5'd1) state_nxt = ADD;
            ADD:   state_nxt = DONE;
            DONE:  if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
    end

    // Operand capture, alignment shifter and registered result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ml   <= '0;
            ms   <= '0;
            sl   <= 1'b0;
            ss   <= 1'b0;
            el   <= '0;
            cnt  <= '0;
            MANT <= '0;
            OVF  <= 1'b0;
            EXP  <= '0;
            SIGN <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        ml  <= l_m;
                        ms  <= s_m;
                        sl  <= l_s;
                        ss  <= s_s;
                        el  <= l_e;
                        cnt <= n;
                    end
                end
                ALIGN: begin
                    ms  <= ms >> 1;
                    cnt <= cnt - 5'd1;
                end
                ADD: begin
                    if (sl == ss) begin
                        {OVF, MANT} <= {1'b0, ml} + {1'b0, ms};
                    end else begin
                        MANT <= ml - ms;
                        OVF  <= 1'b0;
                    end
                    EXP  <= el;
                    SIGN <= sl;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_align_add.sv
// tb_align_add: randomized and directed checks of align_add against a
// behavioural arithmetic model.
module tb_align_add;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        SUB = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [23:0] MANT;
    logic        OVF;
    logic [7:0]  EXP;
    logic        SIGN;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] obs_mant;
    logic        obs_ovf;
    logic [7:0]  obs_exp;
    logic        obs_sign;
    int          obs_lat;

    align_add dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .MANT      (MANT),
        .OVF       (OVF),
        .EXP       (EXP),
        .SIGN      (SIGN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: value-level add of two sign/magnitude operands, smaller one
    // truncated by the exponent difference.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [23:0] m, output logic o,
                                  output logic [7:0] e, output logic s, output int lat);
        longint ea, eb, ma, mb, el_, es_, ml_, ms_, d, tot;
        logic   sa, sb, sl_, ss_;
        ea = (a[30:23] == 0) ? 1 : a[30:23];
        eb = (b[30:23] == 0) ? 1 : b[30:23];
        ma = ((a[30:23] != 0) ? 64'd8388608 : 64'd0) + a[22:0];
        mb = ((b[30:23] != 0) ? 64'd8388608 : 64'd0) + b[22:0];
        sa = a[31];
        sb = b[31] ^ sub;
        if (a[30:0] >= b[30:0]) begin
            el_ = ea; es_ = eb; ml_ = ma; ms_ = mb; sl_ = sa; ss_ = sb;
        end else begin
            el_ = eb; es_ = ea; ml_ = mb; ms_ = ma; sl_ = sb; ss_ = sa;
        end
        d = el_ - es_;
        ms_ = (d >= 32) ? 0 : (ms_ >> d);
        if (sl_ == ss_) begin
            tot = ml_ + ms_;
            o = (tot >= 64'd16777216);
            m = 24'(tot % 64'd16777216);
        end else begin
            m = 24'(ml_ - ms_);
            o = 1'b0;
        end
        e = 8'(el_);
        s = sl_;
        lat = ((d < 24) ? int'(d) : 24) + 1;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input int hold, input bit poke);
        logic [23:0] em;
        logic        eo;
        logic [7:0]  ee;
        logic        es;
        int          el;
        int          lat;
        model(a, b, sub, em, eo, ee, es, el);
        @(negedge CLK);
        check("in_ready_idle", 32'(IN_READY), 32'd1);
        A = a; B = b; SUB = sub; IN_VALID = 1'b1;
        OUT_READY = (hold == 0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; A = $urandom; B = $urandom; SUB = 1'($urandom);
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat <= 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        obs_lat = lat;
        check("latency", 32'(lat), 32'(el));
        if (OUT_VALID !== 1'b1) begin
            OUT_READY = 1'b1;
            return;
        end
        check("mant", 32'(MANT), 32'(em));
        check("ovf", 32'(OVF), 32'(eo));
        check("exp", 32'(EXP), 32'(ee));
        check("sign", 32'(SIGN), 32'(es));
        check("in_ready_done", 32'(IN_READY), 32'd0);
        obs_mant = MANT; obs_ovf = OVF; obs_exp = EXP; obs_sign = SIGN;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                A = $urandom; B = $urandom; SUB = 1'($urandom); IN_VALID = 1'b1;
            end
            @(posedge CLK);
            #1;
            check("hold_valid", 32'(OUT_VALID), 32'd1);
            check("hold_ready", 32'(IN_READY), 32'd0);
            check("hold_mant", 32'(MANT), 32'(em));
            check("hold_ovf", 32'(OVF), 32'(eo));
            check("hold_exp", 32'(EXP), 32'(ee));
            check("hold_sign", 32'(SIGN), 32'(es));
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_after_done", 32'(IN_READY), 32'd1);
        check("valid_after_done", 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          ex;

        // Reset state
        #12;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_outs", {MANT, OVF, EXP[6:0]}, 32'd0);
        check("rst_exp_sign", {23'd0, EXP, SIGN}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed vectors with literal expectations
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 1'b0);
        check("d1_mant", 32'(obs_mant), 32'h000000);
        check("d1_ovf", 32'(obs_ovf), 32'd1);
        check("d1_exp", 32'(obs_exp), 32'h7F);
        check("d1_lat", 32'(obs_lat), 32'd1);

        run_op(32'h3F800000, 32'h3F000000, 1'b0, 0, 1'b0);
        check("d2_mant", 32'(obs_mant), 32'hC00000);
        check("d2_lat", 32'(obs_lat), 32'd2);

        run_op(32'h3F000000, 32'h3F800000, 1'b1, 0, 1'b0);
        check("d3_mant", 32'(obs_mant), 32'h400000);
        check("d3_sign", 32'(obs_sign), 32'd1);

        run_op(32'h3F800000, 32'h3F800000, 1'b1, 0, 1'b0);
        check("d4_mant", 32'(obs_mant), 32'h000000);
        check("d4_ovf_sign", {obs_ovf, obs_sign}, 32'd0);

        run_op(32'h4B800000, 32'h3F800000, 1'b0, 0, 1'b0);
        check("d5_lat", 32'(obs_lat), 32'd25);
        check("d5_mant", 32'(obs_mant), 32'h800000);
        check("d5_exp", 32'(obs_exp), 32'h97);

        run_op(32'h7F000000, 32'h3F800000, 1'b0, 0, 1'b0);
        check("d6_lat", 32'(obs_lat), 32'd25);
        check("d6_mant", 32'(obs_mant), 32'h800000);

        // Backpressure with operand pokes while in DONE
        run_op(32'h40400000, 32'hC0000000, 1'b0, 5, 1'b1);
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 1'b0);
        check("bp_next_mant", 32'(obs_mant), 32'h000000);

        // Reset during alignment of the D=24 case
        @(negedge CLK);
        A = 32'h4B800000; B = 32'h3F800000; SUB = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("arst_out_valid", 32'(OUT_VALID), 32'd0);
        check("arst_in_ready", 32'(IN_READY), 32'd1);
        check("arst_mant", 32'(MANT), 32'd0);
        check("arst_flags", {22'd0, OVF, EXP, SIGN}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 1'b0);
        check("post_rst_mant", 32'(obs_mant), 32'h000000);
        check("post_rst_ovf", 32'(obs_ovf), 32'd1);

        // Randomized operands with biased exponent differences
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = ra ^ 32'h8000_0000;
                2: begin
                    ra[30:23] = 8'(0);
                    rb = {1'($urandom), 8'd0, 23'($urandom)};
                end
                default: begin
                    ex = int'(ra[30:23]) + $urandom_range(0, 60) - 30;
                    if (ex < 0) ex = 0;
                    if (ex > 255) ex = 255;
                    rb = {1'($urandom), 8'(ex), 23'($urandom)};
                end
            endcase
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
